// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_pkg
// Description : Shared defaults and mode constants for the spike counter array.
// Revision    : 1.0 - initial release
// ============================================================================
package spike_pkg;

    localparam int DEF_NCH  = 14;
    localparam int DEF_CW   = 32;
    localparam int DEF_SYNC = 2;

    localparam logic MODE_WINDOWED   = 1'b0;
    localparam logic MODE_CUMULATIVE = 1'b1;

    // Readout index width; a single channel still needs a one-bit select.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_chan_counter.sv
`default_nettype none
// ============================================================================
// Module      : spike_chan_counter
// Description : One spike channel: synchroniser, rising-edge detector,
//               saturating live counter, window shadow and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_chan_counter
    import spike_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int SYNC = DEF_SYNC
) (
    input  logic          clk,
    input  logic          reset_global,
    input  logic          i_spike,
    input  logic          i_arm,
    input  logic          i_win_edge,
    input  logic          i_win_clear,
    output logic [CW-1:0] o_shadow,
    output logic          o_ovf
);

    logic [SYNC-1:0] r_sync;
    logic            r_prev;
    logic [CW-1:0]   r_live;
    logic [CW-1:0]   r_shadow;
    logic            r_ovf;

    logic            w_edge;
    logic            w_at_max;
    logic [CW-1:0]   w_live_next;

    assign w_edge      = i_arm & r_sync[SYNC-1] & ~r_prev;
    assign w_at_max    = (r_live == {CW{1'b1}});
    assign w_live_next = (w_edge && !w_at_max) ? (r_live + CW'(1)) : r_live;

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_spike};
            r_prev <= r_sync[SYNC-1];
        end
    end

    // The snapshot takes the post-increment value so a spike coinciding with
    // the window edge lands in the closing window, not the next one.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else if (i_win_edge) begin
            r_shadow <= w_live_next;
            r_live   <= i_win_clear ? '0 : w_live_next;
        end else begin
            r_live   <= w_live_next;
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_ovf <= 1'b0;
        end else if (w_edge && w_at_max) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/spike_counter_array.sv
`default_nettype none
// ============================================================================
// Module      : spike_counter_array
// Description : NCH-channel spike counter with window snapshots, windowed or
//               cumulative counting, and a registered per-channel readout.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_counter_array
    import spike_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int CW   = DEF_CW,
    parameter int SYNC = DEF_SYNC
) (
    input  logic                      clk,
    input  logic                      reset_global,
    input  logic [NCH-1:0]            spike_in,
    input  logic                      win_clk,
    input  logic                      mode,
    input  logic [sel_width(NCH)-1:0] sel,
    output logic [CW-1:0]             count_out,
    output logic                      win_strobe,
    output logic [NCH-1:0]            ovf
);

    localparam int              ARMW       = $clog2(SYNC + 2);
    localparam logic [ARMW-1:0] c_arm_done = ARMW'(SYNC + 1);

    logic [ARMW-1:0] r_arm_cnt;
    logic            w_armed;

    logic [SYNC-1:0] r_win_sync;
    logic            r_win_prev;
    logic            r_win_strobe;
    logic            w_win_edge;
    logic            w_win_clear;

    logic [CW-1:0]   w_shadow [NCH];
    logic [NCH-1:0]  w_ovf;
    logic            w_sel_valid;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   r_count;

    // Edges stay masked until the synchronisers and edge registers have seen a
    // full pipeline of post-reset samples, so lines already high never count.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + ARMW'(1);
        end
    end

    assign w_armed = (r_arm_cnt == c_arm_done);

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_win_sync   <= '0;
            r_win_prev   <= 1'b0;
            r_win_strobe <= 1'b0;
        end else begin
            r_win_sync   <= {r_win_sync[SYNC-2:0], win_clk};
            r_win_prev   <= r_win_sync[SYNC-1];
            r_win_strobe <= w_win_edge;
        end
    end

    assign w_win_edge = w_armed & r_win_sync[SYNC-1] & ~r_win_prev;

    // mode only matters in the window-edge cycle, so it is effectively
    // sampled there and a mid-window change applies at the next edge.
    assign w_win_clear = (mode == MODE_WINDOWED);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            spike_chan_counter #(
                .CW   (CW),
                .SYNC (SYNC)
            ) u_chan (
                .clk          (clk),
                .reset_global (reset_global),
                .i_spike      (spike_in[gi]),
                .i_arm        (w_armed),
                .i_win_edge   (w_win_edge),
                .i_win_clear  (w_win_clear),
                .o_shadow     (w_shadow[gi]),
                .o_ovf        (w_ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        w_sel_valid  = (32'(sel) < 32'(NCH));
        w_count_next = '0;
        if (w_sel_valid) begin
            w_count_next = w_shadow[sel];
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count_out  = r_count;
    assign win_strobe = r_win_strobe;
    assign ovf        = w_ovf;

endmodule
`default_nettype wire
